// File: rtl/bcd_excess3_pkg.sv
// bcd_excess3_pkg: shared state encoding, BCD constants and digit check
package bcd_excess3_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, SHIFT, DONE} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] E3_OFFSET = 4'd3;
  function automatic logic is_bcd(input logic [3:0] nibble);
    return nibble <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_excess3_serial_ctrl.sv
// bcd_excess3_serial_ctrl: streams a packed BCD word LSB-first through a serial Excess-3 converter and returns the packed result
// Ports: in_valid/in_ready/in_data accept a word; out_valid/out_ready/out_data/out_err return it with a per-digit non-BCD mask;
// busy is high outside IDLE; conv_x/conv_reset_n drive the converter, conv_z is its serial output.
module bcd_excess3_serial_ctrl
  import bcd_excess3_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  localparam int W = 4 * NUM_DIGITS,
  localparam int CW = $clog2(W)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic [NUM_DIGITS-1:0] out_err,
  output logic                  busy,
  output logic                  conv_x,
  output logic                  conv_reset_n,
  input  logic                  conv_z
);
  state_t state_q, state_d;
  logic [W-1:0] shift_q, shift_d, collect_q, collect_d, out_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] err_q, err_d, out_err_d;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    collect_d = collect_q;
    cnt_d = cnt_q;
    err_d = err_q;
    out_data_d = out_data;
    out_err_d = out_err;
    case (state_q)
      IDLE: if (in_valid) begin
        shift_d = in_data;
        collect_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) err_d[i] = !is_bcd(in_data[4*i+:4]);
        state_d = SYNC;
      end
      SYNC: begin
        cnt_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        collect_d[cnt_q] = conv_z;
        shift_d = shift_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          cnt_d = cnt_q;
          state_d = DONE;
          out_err_d = err_q;
          // non-BCD digits were shifted through only to keep converter frames aligned
          for (int i = 0; i < NUM_DIGITS; i++) out_data_d[4*i+:4] = err_q[i] ? 4'h0 : collect_d[4*i+:4];
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      collect_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
      out_data <= '0;
      out_err <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      collect_q <= collect_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      out_data <= out_data_d;
      out_err <= out_err_d;
    end
  end
  assign in_ready = state_q == IDLE && !reset;
  assign busy = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign conv_reset_n = state_q == SHIFT;
  assign conv_x = state_q == SHIFT && shift_q[0];
endmodule

// File: tb/tb_bcd_excess3_serial_ctrl.sv
// tb_bcd_excess3_serial_ctrl: controller plus serial converter model, checked against digit+offset arithmetic
module tb_bcd_excess3_serial_ctrl;
  import bcd_excess3_pkg::*;
  logic clock = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid, busy, conv_x, conv_reset_n, conv_z;
  logic [15:0] out_data;
  logic [3:0] out_err;
  int checks = 0, failures = 0, cyc = 0;
  logic [1:0] cpos;
  logic ccar, k;

  bcd_excess3_serial_ctrl #(.NUM_DIGITS(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .busy(busy), .conv_x(conv_x), .conv_reset_n(conv_reset_n), .conv_z(conv_z)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Mealy serial adder of 4'b0011, LSB first, frame restarted by conv_reset_n
  assign k = cpos < 2'd2;
  assign conv_z = conv_x ^ k ^ ccar;
  always @(posedge clock) begin
    if (!conv_reset_n) begin
      cpos <= 2'd0;
      ccar <= 1'b0;
    end else begin
      cpos <= cpos + 2'd1;
      ccar <= (cpos == 2'd3) ? 1'b0 : ((conv_x & k) | (conv_x & ccar) | (k & ccar));
    end
  end

  function automatic logic [19:0] model(input logic [15:0] d);
    logic [15:0] o;
    logic [3:0] e, nib;
    for (int i = 0; i < 4; i++) begin
      nib = d[4*i+:4];
      e[i] = nib > 4'd9;
      o[4*i+:4] = e[i] ? 4'h0 : nib + E3_OFFSET;
    end
    return {e, o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [15:0] d, input int hold, output int lat, output int vcyc);
    int t0, n;
    logic [19:0] m;
    logic [15:0] snap;
    m = model(d);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clock); n++; end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1; in_data = d; t0 = cyc;
    @(negedge clock);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clock); n++; end
    chk("out_valid_seen", out_valid, 1);
    lat = cyc - t0; vcyc = cyc;
    chk("out_data", out_data, m[15:0]);
    chk("out_err", out_err, m[19:16]);
    snap = out_data;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1; in_data = 16'($urandom);
      @(negedge clock);
      in_valid = 0;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, snap);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_busy", busy, 1);
    end
    out_ready = 1;
    @(negedge clock);
    out_ready = 0;
    chk("release_valid", out_valid, 0);
    chk("idle_hold_data", out_data, snap);
  endtask

  initial begin
    int lat, v1, v2, seen;
    logic [15:0] w;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_conv_x", conv_x, 0);
    chk("rst_conv_reset_n", conv_reset_n, 0);
    @(negedge clock); @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);

    xfer(16'h1234, 0, lat, v1);
    chk("latency_1234", lat, 18);
    xfer(16'h0009, 0, lat, v1);
    chk("latency_0009", lat, 18);
    xfer(16'h9999, 0, lat, v2);
    chk("b2b_period", v2 - v1, 19);
    xfer(16'h9A05, 0, lat, v1);
    xfer(16'h4321, 5, lat, v1);
    xfer(16'h0876, 0, lat, v1);

    in_valid = 1; in_data = 16'h5678;
    @(negedge clock);
    in_valid = 0;
    repeat (9) @(negedge clock);
    chk("mid_busy", busy, 1);
    chk("mid_conv_reset_n", conv_reset_n, 1);
    reset = 1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_err", out_err, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_conv_x", conv_x, 0);
    chk("mid_rst_conv_reset_n", conv_reset_n, 0);
    @(negedge clock);
    reset = 0;
    seen = 0;
    repeat (30) begin @(negedge clock); seen += int'(out_valid); end
    chk("no_emit_after_reset", seen, 0);
    xfer(16'h1234, 0, lat, v1);
    chk("latency_after_reset", lat, 18);

    for (int i = 0; i < 1000; i++) begin
      for (int j = 0; j < 4; j++) w[4*j+:4] = 4'($urandom_range(0, 9));
      xfer(w, $urandom_range(0, 2), lat, v1);
    end
    for (int i = 0; i < 20; i++) xfer(16'($urandom), 0, lat, v1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
